// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice iterated LSB first over WIDTH bits.
// Optional two's-complement Overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_s;
  logic bit_c;

  always_comb begin
    bit_s = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    bit_c = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_a_d  = DataA;
          op_b_d  = DataB;
          carry_d = Cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        carry_d = bit_c;
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        // Only WIDTH-1 partial bits are kept; the MSB sum bit joins them directly into Sum.
        res_d   = (WIDTH-1)'({bit_s, res_q} >> 1);
        if (cnt_q == LAST) begin
          sum_d   = {bit_s, res_q};
          cout_d  = bit_c;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ bit_c;
`endif
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign Overflow = ovf_q;
`endif

endmodule
